// File: rtl/tybec_stream_pkg.sv
// Shared definitions for TyTra stream blocks: decoded-position flag bit
// indices and a width helper that never returns less than one bit.
package tybec_stream_pkg;

    localparam int FLAG_SOL  = 0;
    localparam int FLAG_EOL  = 1;
    localparam int FLAG_SOF  = 2;
    localparam int FLAG_EOF  = 3;
    localparam int NUM_FLAGS = 4;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_index_decoder_counter_wrap.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the enabled
// step that takes the count from MAX back to zero.
module counter_wrap #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // wrap is reported even when clr wins, so the next stage still counts it
    assign wrap = en && (q_q == MAX_V);
    assign q    = q_q;

    always_comb begin
        q_d = q_q;
        if (clr || wrap) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/stream_index_decoder.sv
// Stream index tracker: one register stage that tags each accepted element
// with its (row, col) position, row/frame boundary flags and a frame count.
module stream_index_decoder
    import tybec_stream_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COLS    = 16,
    parameter int ROWS    = 16,
    parameter int FRAME_W = 8,
    localparam int COL_W  = clog2_min1(COLS),
    localparam int ROW_W  = clog2_min1(ROWS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COL_W-1:0]   out_col,
    output logic [ROW_W-1:0]   out_row,
    output logic               out_sol,
    output logic               out_eol,
    output logic               out_sof,
    output logic               out_eof,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic                 accept;
    logic [COL_W-1:0]     col_pos;
    logic [ROW_W-1:0]     row_pos;
    logic                 col_wrap;
    logic                 row_wrap;
    logic [NUM_FLAGS-1:0] flags_d;

    logic [DATA_W-1:0]    data_q;
    logic                 valid_q;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic [NUM_FLAGS-1:0] flags_q;
    logic [FRAME_W-1:0]   frame_q;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    counter_wrap #(.W(COL_W), .MAX(COLS - 1)) u_col (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .clr   (restart),
        .q     (col_pos),
        .wrap  (col_wrap)
    );

    counter_wrap #(.W(ROW_W), .MAX(ROWS - 1)) u_row (
        .clk   (clk),
        .reset (reset),
        .en    (col_wrap),
        .clr   (restart),
        .q     (row_pos),
        .wrap  (row_wrap)
    );

    always_comb begin
        flags_d           = '0;
        flags_d[FLAG_SOL] = (col_pos == '0);
        flags_d[FLAG_EOL] = (col_pos == COL_LAST);
        flags_d[FLAG_SOF] = (col_pos == '0) && (row_pos == '0);
        flags_d[FLAG_EOF] = (col_pos == COL_LAST) && (row_pos == ROW_LAST);
    end

    // Output stage loads only on accept, so a stalled beat holds every field
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            flags_q <= '0;
            frame_q <= '0;
        end else begin
            if (accept) begin
                data_q  <= in_data;
                valid_q <= 1'b1;
                col_q   <= col_pos;
                row_q   <= row_pos;
                flags_q <= flags_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            if (row_wrap) begin
                frame_q <= frame_q + FRAME_W'(1);
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_col   = col_q;
    assign out_row   = row_q;
    assign out_sol   = flags_q[FLAG_SOL];
    assign out_eol   = flags_q[FLAG_EOL];
    assign out_sof   = flags_q[FLAG_SOF];
    assign out_eof   = flags_q[FLAG_EOF];
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_stream_index_decoder.sv
// Scoreboard bench for stream_index_decoder with COLS=4, ROWS=3, FRAME_W=2:
// a linear-position reference model feeds a queue checked by a monitor.
module tb_stream_index_decoder;

    localparam int DATA_W  = 32;
    localparam int COLS    = 4;
    localparam int ROWS    = 3;
    localparam int FRAME_W = 2;
    localparam int N       = COLS * ROWS;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               restart = 1'b0;
    logic [DATA_W-1:0]  in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [1:0]         out_col;
    logic [1:0]         out_row;
    logic               out_sol, out_eol, out_sof, out_eof;
    logic [FRAME_W-1:0] frame_cnt;

    stream_index_decoder #(
        .DATA_W (DATA_W),
        .COLS   (COLS),
        .ROWS   (ROWS),
        .FRAME_W(FRAME_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_col  (out_col),
        .out_row  (out_row),
        .out_sol  (out_sol),
        .out_eol  (out_eol),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                pos;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_p      = 0;
    int   model_frames = 0;
    int   acc_cnt      = 0;
    bit   chk_en       = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Position word {col[1:0], row[1:0], sol, eol, sof, eof} derived from linear index
    function automatic int pos_word(input int p);
        int c, r;
        c = p % COLS;
        r = p / COLS;
        return (c << 6) | (r << 4) | (int'(c == 0) << 3) | (int'(c == COLS - 1) << 2)
             | (int'(p == 0) << 1) | int'(p == N - 1);
    endfunction

    task automatic cycle(input bit iv, input bit ordy, input bit rs, input bit rst);
        bit   acc;
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        restart   = rs;
        reset     = rst;
        in_data   = $urandom;
        #1;
        if (chk_en) chk("frame_cnt", 64'(frame_cnt), 64'(model_frames));
        chk_en = 1;
        acc = iv && (in_ready === 1'b1) && !rst;
        if (rst) begin
            model_p      = 0;
            model_frames = 0;
            sb.delete();
        end else begin
            if (acc) begin
                e.data = in_data;
                e.pos  = pos_word(model_p);
                sb.push_back(e);
                acc_cnt++;
                if (model_p == N - 1) model_frames = (model_frames + 1) % (1 << FRAME_W);
            end
            if (rs) model_p = 0;
            else if (acc) model_p = (model_p + 1) % N;
        end
    endtask

    // Monitor: pops on every transfer and checks stall stability
    logic        hold_prev  = 1'b0;
    logic        reset_prev = 1'b1;
    logic [63:0] prev_snap  = '0;
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] snap;
        #1;
        snap = 64'({out_valid, out_data, out_col, out_row, out_sol, out_eol, out_sof, out_eof});
        if (!$isunknown(out_valid)) begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (hold_prev && !reset_prev) chk("hold", snap, prev_snap);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(out_data), 64'(0));
                    if (out_data == 0) chk("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 64'(out_data), 64'(e.data));
                    chk("beat_pos",
                        64'({out_col, out_row, out_sol, out_eol, out_sof, out_eof}), 64'(e.pos));
                    $display("beat data=%08h col=%0d row=%0d sol=%0b eol=%0b sof=%0b eof=%0b frame=%0d",
                             out_data, out_col, out_row, out_sol, out_eol, out_sof, out_eof, frame_cnt);
                end
            end
        end
        hold_prev  = (out_valid === 1'b1) && (out_ready === 1'b0);
        reset_prev = reset;
        prev_snap  = snap;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, budget, f0;
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 0, 1};

        // Reset state
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_pos", 64'({out_col, out_row, out_sol, out_eol, out_sof, out_eof}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // One full frame, continuous
        for (int i = 0; i < N; i++) cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("frame_after_12", 64'(frame_cnt), 64'(1));

        // Three-cycle stall with a held beat
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0);
            chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);

        // Random handshakes, 1000 beats
        start  = acc_cnt;
        budget = 20000;
        while ((acc_cnt - start) < 1000 && budget > 0) begin
            cycle(1'($urandom % 2), 1'($urandom % 2), 0, 0);
            budget--;
        end
        chk("random_beats", 64'(acc_cnt - start), 64'(1000));
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);

        // Restart coinciding with an accept at (col 2, row 1)
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);
        f0 = int'(frame_cnt);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 0, 0);
        chk("restart_tag", 64'({out_col, out_row}), 64'({2'd2, 2'd1}));
        cycle(0, 1, 0, 0);
        chk("restart_next", 64'({out_col, out_row, out_sof}), 64'({2'd0, 2'd0, 1'b1}));
        chk("restart_frame", 64'(frame_cnt), 64'(f0));

        // Frame counter wrap with FRAME_W=2
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < N; i++) cycle(1, 1, 0, 0);
            cycle(0, 1, 0, 0);
            chk("frame_wrap", 64'(frame_cnt), 64'(exp_seq[f]));
        end

        // Reset while a beat is stalled
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        chk("stall_rst_valid", 64'(out_valid), 64'(0));
        chk("stall_rst_ready", 64'(in_ready), 64'(1));
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("stall_rst_pos", 64'({out_col, out_row, out_sof}), 64'({2'd0, 2'd0, 1'b1}));

        // Drain the scoreboard with a bound
        budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            cycle(0, 1, 0, 0);
            budget--;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
